// File: rtl/user_edge_detect_multi.sv
// user_edge_detect_multi
//   Multi-channel edge detector behind a single OBI subordinate (4KB window).
//   Each channel synchronises an asynchronous input, detects rising/falling
//   edges per a 2-bit MODE field, latches a sticky PENDING bit and counts hits
//   in a saturating counter. irq_o is the OR of PENDING & IRQ_EN.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   obi_req_i        request (always granted in the same cycle)
//   obi_we_i         write enable
//   obi_addr_i       byte address, bits [11:2] decoded
//   obi_wdata_i      write data
//   obi_be_i         byte enables (ignored, full-word access)
//   obi_gnt_o        grant
//   obi_rvalid_o     response valid, one cycle after grant
//   obi_rdata_o      response read data (0 for writes and errors)
//   obi_err_o        response error
//   edge_i           asynchronous monitored inputs
//   irq_o            level interrupt
//
// Register map (byte offsets)
//   0x000 MODE     RW    [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   0x004 PENDING  RW1C
//   0x008 IRQ_EN   RW
//   0x00C LEVEL    RO    synchronised input levels
//   0x100+4i COUNT[i]    read: count, any write clears
module user_edge_detect_multi #(
    parameter int unsigned NumChannels = 8,
    parameter int unsigned CntWidth    = 16,
    parameter int unsigned SyncStages  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   obi_req_i,
    input  logic                   obi_we_i,
    input  logic [31:0]            obi_addr_i,
    input  logic [31:0]            obi_wdata_i,
    input  logic [3:0]             obi_be_i,
    output logic                   obi_gnt_o,
    output logic                   obi_rvalid_o,
    output logic [31:0]            obi_rdata_o,
    output logic                   obi_err_o,
    input  logic [NumChannels-1:0] edge_i,
    output logic                   irq_o
);

    localparam logic [9:0]          CntBase = 10'h040;
    localparam logic [CntWidth-1:0] CntMax  = '1;

    // Synchroniser chain; the last stage is the usable level.
    logic [SyncStages-1:0][NumChannels-1:0] sync_q;
    logic [NumChannels-1:0]                 prev_q;
    logic [NumChannels-1:0]                 level;
    logic [NumChannels-1:0]                 rise;
    logic [NumChannels-1:0]                 fall;
    logic [NumChannels-1:0]                 hit;

    logic [2*NumChannels-1:0] mode_q, mode_d;
    logic [NumChannels-1:0]   pending_q, pending_d;
    logic [NumChannels-1:0]   irq_en_q, irq_en_d;
    logic [CntWidth-1:0]      cnt_q [NumChannels];
    logic [CntWidth-1:0]      cnt_d [NumChannels];
    logic [CntWidth-1:0]      cnt_base [NumChannels];
    logic [NumChannels-1:0]   cnt_clr;

    logic        rvalid_q;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [9:0]  idx;
    logic [9:0]  cnt_off;
    logic        is_cnt;

    logic        unused_bits;
    assign unused_bits = ^{obi_be_i, obi_addr_i[31:12], obi_addr_i[1:0], obi_wdata_i};

    assign level = sync_q[SyncStages-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

    assign idx     = obi_addr_i[11:2];
    assign cnt_off = idx - CntBase;
    assign is_cnt  = (idx >= CntBase) && (idx < CntBase + 10'(NumChannels));

    assign obi_gnt_o    = obi_req_i;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;
    assign irq_o        = |(pending_q & irq_en_q);

    // Hit selection uses the registered MODE, so a MODE write in the same
    // cycle as an edge only affects later cycles.
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            hit[i] = (mode_q[2*i] & rise[i]) | (mode_q[2*i+1] & fall[i]);
        end
    end

    // Bus decode and next-state.
    always_comb begin
        mode_d    = mode_q;
        pending_d = pending_q;
        irq_en_d  = irq_en_q;
        rdata_d   = '0;
        err_d     = 1'b0;
        cnt_clr   = '0;

        if (obi_req_i) begin
            case (idx)
                10'h000: begin
                    if (obi_we_i) mode_d = obi_wdata_i[2*NumChannels-1:0];
                    else          rdata_d = 32'(mode_q);
                end
                10'h001: begin
                    if (obi_we_i) pending_d = pending_q & ~obi_wdata_i[NumChannels-1:0];
                    else          rdata_d = 32'(pending_q);
                end
                10'h002: begin
                    if (obi_we_i) irq_en_d = obi_wdata_i[NumChannels-1:0];
                    else          rdata_d = 32'(irq_en_q);
                end
                10'h003: begin
                    if (obi_we_i) err_d = 1'b1;
                    else          rdata_d = 32'(level);
                end
                default: begin
                    if (is_cnt) begin
                        for (int unsigned i = 0; i < NumChannels; i++) begin
                            if (cnt_off == 10'(i)) begin
                                if (obi_we_i) cnt_clr[i] = 1'b1;
                                else          rdata_d = 32'(cnt_q[i]);
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end

        // Set wins over W1C.
        pending_d = pending_d | hit;

        // Clear is applied before the increment so a clear+hit leaves 1.
        for (int unsigned i = 0; i < NumChannels; i++) begin
            cnt_base[i] = cnt_clr[i] ? '0 : cnt_q[i];
            cnt_d[i]    = (hit[i] && (cnt_base[i] != CntMax)) ?
                          cnt_base[i] + CntWidth'(1) : cnt_base[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            prev_q    <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            irq_en_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < NumChannels; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q    <= {sync_q[SyncStages-2:0], edge_i};
            prev_q    <= level;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            irq_en_q  <= irq_en_d;
            rvalid_q  <= obi_req_i;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            for (int unsigned i = 0; i < NumChannels; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
